// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered eight-op ALU with an iterative restoring divider
// Start/busy/done handshake; every output comes straight from a flop.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             div_by_zero
);

  typedef enum logic {
    IDLE   = 1'b0,
    DIVIDE = 1'b1
  } state_t;

  localparam logic [2:0]       OP_DIV   = 3'b111;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   shifted;
  logic             step_ge;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  always_comb begin
    logic_res = '0;
    case (select)
      3'b000:  logic_res = a & b;
      3'b001:  logic_res = ~(a & b);
      3'b010:  logic_res = a | b;
      3'b011:  logic_res = ~(a | b);
      3'b100:  logic_res = a ^ b;
      3'b101:  logic_res = ~(a ^ b);
      3'b110:  logic_res = ~a;
      default: logic_res = '0;
    endcase
  end

  // One restoring step: the quotient bit is shifted into the vacated dividend LSB.
  always_comb begin
    shifted  = {prem_q, dvd_q[WIDTH-1]};
    step_ge  = (shifted >= {1'b0, dvs_q});
    step_rem = step_ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], step_ge};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    remainder_d = remainder_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (select != OP_DIV) begin
            result_d    = logic_res;
            remainder_d = '0;
            zero_d      = (logic_res == '0);
            dbz_d       = 1'b0;
            done_d      = 1'b1;
          end else if (b == '0) begin
            result_d    = '0;
            remainder_d = '0;
            zero_d      = 1'b1;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end else begin
            dvd_d   = a;
            dvs_d   = b;
            prem_d  = '0;
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
            state_d = DIVIDE;
          end
        end
      end

      DIVIDE: begin
        prem_d = step_rem;
        dvd_d  = step_quo;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d    = step_quo;
          remainder_d = step_rem;
          zero_d      = (step_quo == '0);
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign remainder   = remainder_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed-vector bench for seq_alu at WIDTH=16 and WIDTH=8
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0]  sel16 = '0;
  logic        busy16, done16, zero16, dbz16;
  logic [15:0] res16, rem16;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  sel8 = '0;
  logic        busy8, done8, zero8, dbz8;
  logic [7:0]  res8, rem8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .select(sel16),
    .busy(busy16), .done(done16), .result(res16), .remainder(rem16),
    .zero(zero16), .div_by_zero(dbz16)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .select(sel8),
    .busy(busy8), .done(done8), .result(res8), .remainder(rem8),
    .zero(zero8), .div_by_zero(dbz8)
  );

  task automatic go16(input logic [15:0] aa, input logic [15:0] bb, input logic [2:0] ss);
    @(negedge clk);
    a16 = aa; b16 = bb; sel16 = ss; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
  endtask

  task automatic go8(input logic [7:0] aa, input logic [7:0] bb, input logic [2:0] ss);
    @(negedge clk);
    a8 = aa; b8 = bb; sel8 = ss; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  // Called just after the accepting edge; counts busy cycles until done, bounded.
  task automatic wait_done(input bit use8, output int bcnt, output bit got);
    bcnt = 0;
    got  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (use8 ? busy8 : busy16) bcnt++;
      if (use8 ? done8 : done16) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy16, done16, res16, rem16, zero16, dbz16} !== 36'h0) begin
      n_err++;
      $display("FAIL reset16 got busy=%b done=%b res=%h rem=%h z=%b dbz=%b want all 0",
               busy16, done16, res16, rem16, zero16, dbz16);
    end
    n_cmp++;
    if ({busy8, done8, res8, rem8, zero8, dbz8} !== 20'h0) begin
      n_err++;
      $display("FAIL reset8 got busy=%b done=%b res=%h rem=%h z=%b dbz=%b want all 0",
               busy8, done8, res8, rem8, zero8, dbz8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_logic_ops;
    go16(16'h000C, 16'h000C, 3'b000);
    n_cmp++;
    if ({done16, res16, rem16, zero16, dbz16} !== {1'b1, 16'h000C, 16'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL and16 got done=%b res=%h rem=%h z=%b want done=1 res=000c rem=0 z=0",
               done16, res16, rem16, zero16);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done16 !== 1'b0 || res16 !== 16'h000C) begin
      n_err++;
      $display("FAIL hold16 got done=%b res=%h want done=0 res=000c", done16, res16);
    end
    go16(16'h000C, 16'h000C, 3'b100);
    n_cmp++;
    if (done16 !== 1'b1 || res16 !== 16'h0000 || zero16 !== 1'b1) begin
      n_err++;
      $display("FAIL xor16 got done=%b res=%h z=%b want done=1 res=0000 z=1", done16, res16, zero16);
    end
    go16(16'h10A4, 16'h0000, 3'b110);
    n_cmp++;
    if (done16 !== 1'b1 || res16 !== 16'hEF5B || zero16 !== 1'b0) begin
      n_err++;
      $display("FAIL not16 got done=%b res=%h z=%b want done=1 res=ef5b z=0", done16, res16, zero16);
    end
    go16(16'h10A4, 16'h1184, 3'b101);
    n_cmp++;
    if (res16 !== 16'hFEDF) begin
      n_err++;
      $display("FAIL xnor16 got res=%h want fedf", res16);
    end
    go16(16'hF0F0, 16'hFF00, 3'b001);
    n_cmp++;
    if (res16 !== 16'h0FFF) begin
      n_err++;
      $display("FAIL nand16 got res=%h want 0fff", res16);
    end
  endtask

  task automatic test_divide;
    int  bc;
    bit  got;
    go16(16'd100, 16'd7, 3'b111);
    wait_done(1'b0, bc, got);
    n_cmp++;
    if (!got || bc !== 16) begin
      n_err++;
      $display("FAIL div16_busy got done_seen=%0d busy_cycles=%0d want 1 and 16", got, bc);
    end
    n_cmp++;
    if (res16 !== 16'd14 || rem16 !== 16'd2 || dbz16 !== 1'b0 || zero16 !== 1'b0) begin
      n_err++;
      $display("FAIL div16_100_7 got q=%0d r=%0d dbz=%b z=%b want q=14 r=2 dbz=0 z=0",
               res16, rem16, dbz16, zero16);
    end
    go16(16'hFFFF, 16'h0001, 3'b111);
    wait_done(1'b0, bc, got);
    n_cmp++;
    if (!got || res16 !== 16'hFFFF || rem16 !== 16'h0000) begin
      n_err++;
      $display("FAIL div16_ffff_1 got done_seen=%0d q=%h r=%h want 1 q=ffff r=0000", got, res16, rem16);
    end
    go16(16'd5, 16'd9, 3'b111);
    wait_done(1'b0, bc, got);
    n_cmp++;
    if (!got || res16 !== 16'd0 || rem16 !== 16'd5 || zero16 !== 1'b1) begin
      n_err++;
      $display("FAIL div16_5_9 got done_seen=%0d q=%0d r=%0d z=%b want 1 q=0 r=5 z=1",
               got, res16, rem16, zero16);
    end
  endtask

  task automatic test_div_by_zero;
    go16(16'd55, 16'd0, 3'b111);
    n_cmp++;
    if ({done16, res16, zero16, dbz16, busy16} !== {1'b1, 16'h0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL dbz16 got done=%b res=%h z=%b dbz=%b busy=%b want 1 0000 1 1 0",
               done16, res16, zero16, dbz16, busy16);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || dbz16 !== 1'b1) begin
      n_err++;
      $display("FAIL dbz16_after got busy=%b done=%b dbz=%b want 0 0 1", busy16, done16, dbz16);
    end
  endtask

  task automatic test_ignore_and_abort;
    int bc;
    bit got;
    int pulses;
    go16(16'd100, 16'd7, 3'b111);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; sel16 = 3'b000; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    wait_done(1'b0, bc, got);
    n_cmp++;
    if (!got || bc !== 11 || res16 !== 16'd14 || rem16 !== 16'd2) begin
      n_err++;
      $display("FAIL ignore16 got done_seen=%0d busy_left=%0d q=%0d r=%0d want 1 11 14 2",
               got, bc, res16, rem16);
    end
    go16(16'd100, 16'd7, 3'b111);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy16, done16, res16, rem16, zero16, dbz16} !== 36'h0) begin
      n_err++;
      $display("FAIL abort16 got busy=%b done=%b res=%h rem=%h want all 0", busy16, done16, res16, rem16);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done16 || busy16) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL abort16_quiet got activity_cycles=%0d want 0", pulses);
    end
    go16(16'h000C, 16'h000C, 3'b000);
    n_cmp++;
    if (done16 !== 1'b1 || res16 !== 16'h000C) begin
      n_err++;
      $display("FAIL restart16 got done=%b res=%h want 1 000c", done16, res16);
    end
  endtask

  task automatic test_back_to_back;
    int bc;
    bit got;
    go8(8'd200, 8'd3, 3'b111);
    wait_done(1'b1, bc, got);
    n_cmp++;
    if (!got || bc !== 8 || res8 !== 8'd66 || rem8 !== 8'd2) begin
      n_err++;
      $display("FAIL div8 got done_seen=%0d busy_cycles=%0d q=%0d r=%0d want 1 8 66 2",
               got, bc, res8, rem8);
    end
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd3; sel8 = 3'b010; start8 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (done8 !== 1'b1 || res8 !== 8'hCB || rem8 !== 8'h00) begin
      n_err++;
      $display("FAIL b2b8_or got done=%b res=%h rem=%h want 1 cb 00", done8, res8, rem8);
    end
    @(negedge clk);
    sel8 = 3'b011;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_cmp++;
    if (done8 !== 1'b1 || res8 !== 8'h34) begin
      n_err++;
      $display("FAIL b2b8_nor got done=%b res=%h want 1 34", done8, res8);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done8 !== 1'b0 || res8 !== 8'h34) begin
      n_err++;
      $display("FAIL b2b8_end got done=%b res=%h want 0 34", done8, res8);
    end
    go8(8'd0, 8'd0, 3'b111);
    n_cmp++;
    if (done8 !== 1'b1 || dbz8 !== 1'b1 || zero8 !== 1'b1 || busy8 !== 1'b0) begin
      n_err++;
      $display("FAIL dbz8 got done=%b dbz=%b z=%b busy=%b want 1 1 1 0", done8, dbz8, zero8, busy8);
    end
  endtask

  initial begin
    test_reset;
    test_logic_ops;
    test_divide;
    test_div_by_zero;
    test_ignore_and_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 16-bit select-driven ALU. Performs the eight standard operations on WIDTH-bit operands under a start/busy/done handshake.
- Logic operations complete in one cycle. Division is an iterative restoring divider taking WIDTH cycles, and produces both quotient and remainder.
- Result, remainder and status flags are held in output registers until the next operation completes. Sits between the operand/opcode source and the accumulator/datapath consumer.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A (dividend for DIV)
- b  input  WIDTH  operand B (divisor for DIV; ignored for NOT)
- select  input  3  opcode: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 DIV
- busy  output  1  high while a division is iterating
- done  output  1  one-cycle pulse when result/remainder/flags update
- result  output  WIDTH  registered result (quotient for DIV)
- remainder  output  WIDTH  registered remainder; 0 for non-DIV ops
- zero  output  1  registered: result == 0
- div_by_zero  output  1  registered: last completed op was DIV with b == 0

Behaviour:
- Reset: rst=1 asynchronously forces state IDLE, counter 0, and all internal operand registers to 0. It also forces busy=0, done=0, result=0, remainder=0, zero=0, div_by_zero=0. Holding rst high holds these values. Reset during DIVIDE aborts the division with no done pulse.
- States: IDLE, DIVIDE.
- IDLE, start=0: outputs hold; done=0.
- IDLE, start=1, select != 111, at edge E0:
  - result <= op(a,b), bitwise.
  - remainder <= 0; div_by_zero <= 0; zero <= (op result == 0).
  - done=1 for the cycle after E0. Stay in IDLE. Latency 1 cycle.
- IDLE, start=1, select=111, b=0, at E0:
  - result <= 0; remainder <= 0; div_by_zero <= 1; zero <= 1.
  - done=1 for one cycle. Stay in IDLE. No division cycles.
- IDLE, start=1, select=111, b != 0, at E0:
  - Capture a into dividend shift register and b into divisor register; partial remainder <= 0; counter <= WIDTH.
  - Go to DIVIDE; busy=1. result, remainder and flags are not modified yet.
- DIVIDE, each edge E1..E_WIDTH: one restoring step, MSB first.
  - Shift partial remainder left by one, bringing in the dividend MSB. Shift the dividend left.
  - If the shifted remainder >= divisor: subtract the divisor and shift 1 into the quotient; otherwise shift 0.
  - Decrement the counter. The comparison/subtraction is done at WIDTH+1 bits; no overflow is possible.
- At E_WIDTH (counter reaches 0):
  - result <= quotient; remainder <= final partial remainder.
  - zero <= (quotient == 0); div_by_zero <= 0.
  - done=1 for the following cycle; busy=0; return to IDLE.
  - Total: busy high for exactly WIDTH cycles; done is asserted WIDTH cycles after E0.
- Handshake rules:
  - start while busy=1 (including the edge E_WIDTH) is ignored and not queued; no error flag.
  - start in the cycle where done=1 is accepted, giving back-to-back operation. A logic op can then complete every cycle with done held high continuously.
  - a, b and select need only be valid at the accepting edge; changes during DIVIDE have no effect.
- Arithmetic: unsigned only. quotient*b + remainder == a and remainder < b for every b != 0.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=16. start with a=0x000C, b=0x000C, select=000 -> next cycle done=1, result=0x000C, remainder=0, zero=0. Then select=100 with the same operands -> result=0x0000, zero=1.
- a=0x10A4, select=110 -> result=0xEF5B after 1 cycle. Then a=0x10A4, b=0x1184, select=101 -> result=0xFEDF.
- a=100, b=7, select=111 -> busy=1 for 16 cycles, then done=1, result=14, remainder=2, div_by_zero=0. Also a=0xFFFF, b=1 -> result=0xFFFF, remainder=0.
- a=55, b=0, select=111 -> 1 cycle later done=1, result=0, zero=1, div_by_zero=1; busy never rises.
- Start a DIV of 100/7. Assert start with select=000 at cycle 5 (ignored; result still 14 at completion). Assert rst for 1 cycle at cycle 10 of a second division -> all outputs 0 immediately, no done pulse; the next start is accepted normally.
- WIDTH=8 instance: a=200, b=3, select=111 -> busy=1 for 8 cycles, result=66, remainder=2. Then back-to-back starts with select=010, 011 -> done high for 2 consecutive cycles with results a|b and ~(a|b).
